console_uart: RTL and testbench
===============================

Name: console_uart

Overview:
- 8N1 serial UART core for the PDP-8 console (TTI/TTO) controller.
- Converts parallel bytes to and from a serial line.
- Exchanges bytes with the console controller over two four-phase req/ack handshakes.
- Bit timing comes from external baud tick enables produced by the baud-rate generator; everything runs in the single `clk` domain.

Parameters:
- RX_OVERSAMPLE, 16, number of rx_clk ticks per bit period (must be even, >= 4).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_clk  input  1  transmit baud tick; one-clk-wide pulse, once per bit period.
- tx_req  input  1  controller request to transmit tx_data.
- tx_data  input  8  byte to send; stable while tx_req=1.
- tx_ack  output  1  transmit handshake acknowledge.
- tx_empty  output  1  1 = transmitter idle, no byte pending or shifting.
- rx_clk  input  1  receive oversample tick; pulse, RX_OVERSAMPLE per bit period.
- rx_req  input  1  controller request to take the received byte.
- rx_ack  output  1  receive handshake acknowledge.
- rx_data  output  8  last received byte.
- rx_empty  output  1  0 = unread byte in holding register.
- rx_in  input  1  serial input; asynchronous, idle high.
- tx_out  output  1  serial output; idle high.

Behaviour:
- Reset (async, any time, including mid-frame): tx_out=1, tx_ack=0, tx_empty=1, rx_ack=0, rx_empty=1, rx_data=0.
  - Both state machines return to idle; any partial frame is dropped.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX handshake:
  - In TX idle with tx_req=1: on the next clk edge, latch tx_data, set tx_ack=1 and tx_empty=0 in the same edge.
  - tx_ack stays 1 until tx_req is seen 0, then clears on the next edge.
  - A new byte is not accepted while tx_ack=1 or tx_empty=0.
- TX shifter:
  - After latch, wait for the next tx_clk tick, then drive the start bit.
  - Each subsequent tx_clk tick advances one bit: 8 data bits, then stop bit.
  - At the tx_clk tick ending the stop bit period: tx_out=1, tx_empty=1.
  - Frame length is exactly 10 tx_clk periods after the first tick.
  - The shifter advances only on tx_clk, independent of handshake state.
- RX front end: rx_in passes through a 2-flop synchronizer; the RX state machine samples only on rx_clk ticks.
- RX state machine:
  - IDLE: a 0 seen on an rx_clk tick -> START.
  - START: after RX_OVERSAMPLE/2 ticks, re-sample. Still 0 -> DATA; 1 -> false start, back to IDLE.
  - DATA: sample every RX_OVERSAMPLE ticks (mid-bit), 8 bits LSB first -> STOP.
  - STOP: sample after RX_OVERSAMPLE ticks.
    - 1: load rx_data with the byte, rx_empty=0, -> IDLE.
    - 0: framing error; discard the byte, rx_data/rx_empty unchanged, wait for rx_in=1, -> IDLE.
- RX handshake:
  - rx_req=1 with rx_empty=0 and rx_ack=0: next edge sets rx_ack=1 and rx_empty=1 together.
  - rx_ack clears on the first edge after rx_req is seen 0.
  - rx_req=1 while rx_empty=1: ignored; no ack.
- rx_data holds its value until the next valid frame completes, so it stays stable after the handshake for a later read.
- Overrun: a new valid frame completing while rx_empty=0 overwrites rx_data; rx_empty stays 0. No error flag.
- Frame completion and ack on the same edge: ack takes the old byte and sets rx_empty=1. The new byte then loads on the following edge, setting rx_empty=0.
- TX and RX are fully independent; full duplex.

Test Plan:
- Reset check: assert reset mid-TX frame -> tx_out=1, tx_empty=1, tx_ack=0, rx_empty=1, rx_data=8'h00 immediately (async), held after release.
- TX byte 8'h55: req/ack handshake completes; tx_empty=0 from the ack edge; tx_out over 10 ticks is 0,1,0,1,0,1,0,1,0,1; tx_empty=1 after the stop tick.
- RX byte 8'hA3: drive a correct 8N1 frame at 16 rx_clk ticks/bit -> rx_empty=0, rx_data=8'hA3. Then rx_req -> rx_ack=1 and rx_empty=1 on the same edge; drop req -> rx_ack=0; rx_data still 8'hA3.
- Loopback tx_out->rx_in, send 8'h00 then 8'hFF -> both received intact, in order.
- RX glitch: a 0 pulse of 3 rx_clk ticks -> no byte, rx_empty stays 1. Frame 8'h41 with stop bit 0 -> discarded, rx_empty stays 1.
- RX overrun: two frames 8'h12, 8'h34 without a handshake -> rx_data=8'h34, rx_empty=0; one handshake -> rx_empty=1.

Source files
------------

// File: rtl/console_uart.sv
// 8N1 serial UART core for the PDP-8 console controller: one byte-wide
// transmitter and one oversampling receiver, each with a four-phase req/ack port.
module console_uart #(
  parameter int RX_OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_clk,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       tx_empty,
  input  logic       rx_clk,
  input  logic       rx_req,
  output logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  input  logic       rx_in,
  output logic       tx_out
);

  localparam int CW = $clog2(RX_OVERSAMPLE);
  localparam logic [CW-1:0] LAST      = CW'(RX_OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(RX_OVERSAMPLE / 2 - 1);

  // Handshakes are four-phase: ack rises one edge after req is seen with the
  // port ready, stays high while req is high, and falls one edge after req
  // drops; a new transfer can only start once both req and ack are low.

  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SHIFT} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  tx_state_t  tx_state, tx_state_d;
  logic [7:0] tx_buf, tx_buf_d;
  logic [3:0] tx_bit, tx_bit_d;
  logic       tx_out_d, tx_ack_d, tx_empty_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_buf   <= 8'h00;
      tx_bit   <= 4'd0;
      tx_out   <= 1'b1;
      tx_ack   <= 1'b0;
      tx_empty <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_buf   <= tx_buf_d;
      tx_bit   <= tx_bit_d;
      tx_out   <= tx_out_d;
      tx_ack   <= tx_ack_d;
      tx_empty <= tx_empty_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    tx_buf_d   = tx_buf;
    tx_bit_d   = tx_bit;
    tx_out_d   = tx_out;
    tx_ack_d   = tx_ack;
    tx_empty_d = tx_empty;
    if (tx_ack && !tx_req) tx_ack_d = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_req && !tx_ack) begin
          tx_buf_d   = tx_data;
          tx_ack_d   = 1'b1;
          tx_empty_d = 1'b0;
          tx_state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tx_clk) begin
          tx_out_d   = 1'b0;
          tx_bit_d   = 4'd0;
          tx_state_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        // tx_bit 0..7 selects data, 8 drives the stop bit, 9 ends the frame
        if (tx_clk) begin
          if (tx_bit < 4'd8) begin
            tx_out_d = tx_buf[tx_bit[2:0]];
            tx_bit_d = tx_bit + 4'd1;
          end else if (tx_bit == 4'd8) begin
            tx_out_d = 1'b1;
            tx_bit_d = 4'd9;
          end else begin
            tx_out_d   = 1'b1;
            tx_empty_d = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  rx_state_t     rx_state, rx_state_d;
  logic [CW-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]    rx_bit, rx_bit_d;
  logic [7:0]    rx_shift, rx_shift_d;
  logic [7:0]    rx_data_d;
  logic          rx_ack_d, rx_empty_d, rx_pend, rx_pend_d;
  logic          rx_meta, rx_s;
  logic          ack_fire, frame_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_ack   <= 1'b0;
      rx_empty <= 1'b1;
      rx_pend  <= 1'b0;
    end else begin
      rx_meta  <= rx_in;
      rx_s     <= rx_meta;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
      rx_data  <= rx_data_d;
      rx_ack   <= rx_ack_d;
      rx_empty <= rx_empty_d;
      rx_pend  <= rx_pend_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_data_d  = rx_data;
    rx_ack_d   = rx_ack;
    rx_empty_d = rx_empty;
    rx_pend_d  = rx_pend;
    frame_ok   = 1'b0;
    ack_fire   = rx_req && !rx_empty && !rx_ack;
    if (rx_ack && !rx_req) rx_ack_d = 1'b0;
    if (ack_fire) begin
      rx_ack_d   = 1'b1;
      rx_empty_d = 1'b1;
    end
    case (rx_state)
      RX_IDLE: begin
        if (rx_clk && !rx_s) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_clk) begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt_d   = '0;
            rx_bit_d   = 3'd0;
            rx_state_d = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_d = rx_cnt + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (rx_clk) begin
          if (rx_cnt == LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_s, rx_shift[7:1]};
            rx_bit_d   = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state_d = RX_STOP;
          end else begin
            rx_cnt_d = rx_cnt + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (rx_clk) begin
          if (rx_cnt == LAST) begin
            rx_cnt_d = '0;
            if (rx_s) begin
              frame_ok   = 1'b1;
              rx_state_d = RX_IDLE;
            end else begin
              rx_state_d = RX_WAIT_HIGH;
            end
          end else begin
            rx_cnt_d = rx_cnt + 1'b1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_clk && rx_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    // A completed frame yields to a same-edge ack and loads one edge later;
    // rx_shift is untouched until the next frame's data bits, so it holds the byte.
    if (frame_ok || rx_pend) begin
      if (ack_fire) begin
        rx_pend_d = 1'b1;
      end else begin
        rx_data_d  = rx_shift;
        rx_empty_d = 1'b0;
        rx_pend_d  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_console_uart.sv
// Directed bench for console_uart: handshakes, TX bit sequence, RX framing,
// glitch/framing-error rejection, overrun, loopback and async reset.
module tb_console_uart;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_clk = 1'b0;
  logic       rx_clk = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_req = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loopback = 1'b0;
  logic       rx_in;
  logic       tx_ack, tx_empty, rx_ack, rx_empty, tx_out;
  logic [7:0] rx_data;

  assign rx_in = loopback ? tx_out : rx_drv;

  console_uart #(.RX_OVERSAMPLE(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_clk   (tx_clk),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_ack   (tx_ack),
    .tx_empty (tx_empty),
    .rx_clk   (rx_clk),
    .rx_req   (rx_req),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_empty (rx_empty),
    .rx_in    (rx_in),
    .tx_out   (tx_out)
  );

  // Clock and baud ticks: rx tick every 4 clk, tx tick every 64 clk (16 rx ticks/bit)
  always #5 clk = ~clk;

  int unsigned div = 0;
  always @(negedge clk) begin
    div    = div + 1;
    rx_clk = (div % 4 == 0);
    tx_clk = (div % 64 == 0);
  end

  // Scoreboard: bytes the receiver should be holding, plus the last byte read
  logic [7:0] exp_q[$];
  logic [7:0] last_rx = 8'h00;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    exp_q.push_back(b);
  endtask

  // Drivers
  task automatic wait_rx_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (rx_clk) k++;
    end
  endtask

  task automatic wait_tx_tick();
    int k;
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (!tx_clk && k < 200);
    if (!tx_clk) begin
      n_checks++;
      $display("FAIL tx_tick_timeout: got no tick expected tick within 200 clk");
    end
  endtask

  task automatic drive_rx(input logic b, input int ticks);
    @(negedge clk);
    rx_drv = b;
    wait_rx_ticks(ticks);
  endtask

  task automatic send_rx_frame(input logic [7:0] d, input logic stop);
    drive_rx(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_rx(d[i], 16);
    drive_rx(stop, 16);
    drive_rx(1'b1, 8);
  endtask

  task automatic tx_send(input string tag, input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_req  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_ack"}, tx_ack, 1'b1);
    check_eq({tag, "_busy"}, tx_empty, 1'b0);
    tx_req = 1'b0;
  endtask

  task automatic wait_tx_empty(input string tag);
    int k;
    k = 0;
    while (!tx_empty && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_done"}, tx_empty, 1'b1);
  endtask

  task automatic rx_read(input string tag);
    logic [7:0] e;
    e = 8'h00;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s_queue: got empty scoreboard expected a byte", tag);
    end else begin
      e = exp_q.pop_front();
    end
    last_rx = e;
    @(negedge clk);
    rx_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_ack"}, rx_ack, 1'b1);
    check_eq({tag, "_empty"}, rx_empty, 1'b1);
    rx_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_ack_drop"}, rx_ack, 1'b0);
    check_eq({tag, "_data"}, rx_data, e);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_tx_out"}, tx_out, 1'b1);
    check_eq({tag, "_tx_empty"}, tx_empty, 1'b1);
    check_eq({tag, "_tx_ack"}, tx_ack, 1'b0);
    check_eq({tag, "_rx_ack"}, rx_ack, 1'b0);
    check_eq({tag, "_rx_empty"}, rx_empty, 1'b1);
    check_eq({tag, "_rx_data"}, rx_data, 8'h00);
  endtask

  logic [9:0] seq_55 = 10'b1010101010;

  initial begin
    // Power-on reset
    repeat (3) @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("por_rel");

    // RX byte A3, then read it
    expect_byte(8'hA3);
    send_rx_frame(8'hA3, 1'b1);
    check_eq("rx_a3_full", rx_empty, exp_q.size() == 0);
    check_eq("rx_a3_data", rx_data, 8'hA3);
    rx_read("rx_a3");
    repeat (4) @(negedge clk);
    check_eq("rx_a3_hold", rx_data, last_rx);

    // TX byte 55: start, 8 data bits, stop, then idle
    tx_send("tx_55", 8'h55);
    for (int i = 0; i < 10; i++) begin
      wait_tx_tick();
      @(negedge clk);
      check_eq($sformatf("tx_55_bit%0d", i), tx_out, seq_55[i]);
    end
    check_eq("tx_55_busy_stop", tx_empty, 1'b0);
    wait_tx_tick();
    @(negedge clk);
    check_eq("tx_55_empty", tx_empty, 1'b1);
    check_eq("tx_55_idle", tx_out, 1'b1);
    check_eq("tx_55_ack_low", tx_ack, 1'b0);

    // Async reset mid-frame, with an unread RX byte pending
    expect_byte(8'h5A);
    send_rx_frame(8'h5A, 1'b1);
    check_eq("rx_5a_data", rx_data, 8'h5A);
    tx_send("tx_3c", 8'h3C);
    wait_tx_tick();
    wait_tx_tick();
    @(negedge clk);
    check_eq("tx_3c_bit0", tx_out, 1'b0);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    last_rx = 8'h00;
    check_reset_state("mid_rst");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("mid_rel");
    wait_tx_tick();
    wait_tx_tick();
    @(negedge clk);
    check_eq("mid_rel_tx_quiet", tx_out, 1'b1);

    // Loopback 00 then FF
    loopback = 1'b1;
    tx_send("lb_00", 8'h00);
    expect_byte(8'h00);
    wait_tx_empty("lb_00");
    wait_rx_ticks(4);
    check_eq("lb_00_full", rx_empty, 1'b0);
    rx_read("lb_00");
    tx_send("lb_ff", 8'hFF);
    expect_byte(8'hFF);
    wait_tx_empty("lb_ff");
    wait_rx_ticks(4);
    check_eq("lb_ff_full", rx_empty, 1'b0);
    rx_read("lb_ff");
    @(negedge clk);
    loopback = 1'b0;
    rx_drv   = 1'b1;
    wait_rx_ticks(16);

    // Glitch, ignored request, framing error
    drive_rx(1'b0, 3);
    drive_rx(1'b1, 20);
    check_eq("glitch_empty", rx_empty, 1'b1);
    @(negedge clk);
    rx_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("idle_req_no_ack", rx_ack, 1'b0);
    rx_req = 1'b0;
    send_rx_frame(8'h41, 1'b0);
    wait_rx_ticks(16);
    check_eq("frame_err_empty", rx_empty, 1'b1);
    check_eq("frame_err_data", rx_data, last_rx);

    // Overrun: second frame replaces the unread first one
    expect_byte(8'h12);
    send_rx_frame(8'h12, 1'b1);
    check_eq("ovr_12_data", rx_data, 8'h12);
    expect_byte(8'h34);
    send_rx_frame(8'h34, 1'b1);
    check_eq("ovr_full", rx_empty, 1'b0);
    check_eq("ovr_data", rx_data, 8'h34);
    rx_read("ovr");
    repeat (4) @(negedge clk);
    check_eq("ovr_empty_after", rx_empty, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
